// File: rtl/muldiv_sched_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer.
// The master side drives EX-stage requests; the slave side returns stall, status and HI/LO.
interface muldiv_sched_if;
  logic        MDStart_IDEX;
  logic [1:0]  MDOp_IDEX;
  logic [31:0] OpA_IDEX;
  logic [31:0] OpB_IDEX;
  logic        HiLoRd_IDEX;
  logic        WrHi_IDEX;
  logic        WrLo_IDEX;
  logic [31:0] WrData_IDEX;
  logic        Cancel;
  logic        MD_Stall;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output MDStart_IDEX, MDOp_IDEX, OpA_IDEX, OpB_IDEX,
    output HiLoRd_IDEX, WrHi_IDEX, WrLo_IDEX, WrData_IDEX, Cancel,
    input  MD_Stall, Busy, Done, Hi, Lo
  );

  modport slave (
    input  MDStart_IDEX, MDOp_IDEX, OpA_IDEX, OpB_IDEX,
    input  HiLoRd_IDEX, WrHi_IDEX, WrLo_IDEX, WrData_IDEX, Cancel,
    output MD_Stall, Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/muldiv_sched.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO, with stall generation.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU; division unchanged.
module muldiv_sched (
  input  logic         CLK,
  input  logic         RST_n,
  muldiv_sched_if.slave md
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        isDivReg;
  logic        divZero;
  logic        negQ;
  logic        negR;
  logic [31:0] rawA;
  logic [31:0] mcand;
  logic [63:0] acc;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;

  logic        signedOp;
  logic        isDiv;
  logic        sgnA;
  logic        sgnB;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divTrial;
  logic [63:0] divNext;
  logic [63:0] prodFix;
  logic [31:0] quotFix;
  logic [31:0] remFix;
`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fastProd;
`endif

  always_comb begin
    signedOp = ~md.MDOp_IDEX[0];
    isDiv    = md.MDOp_IDEX[1];
    sgnA     = signedOp & md.OpA_IDEX[31];
    sgnB     = signedOp & md.OpB_IDEX[31];
    absA     = sgnA ? (32'd0 - md.OpA_IDEX) : md.OpA_IDEX;
    absB     = sgnB ? (32'd0 - md.OpB_IDEX) : md.OpB_IDEX;
`ifdef MULDIV_FAST_MULT_EN
    fastProd = {{32{sgnA}}, md.OpA_IDEX} * {{32{sgnB}}, md.OpB_IDEX};
`endif
  end

  // acc holds product {upper, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + {1'b0, mcand};
    mulNext  = acc[0] ? {mulSum, acc[31:1]} : {1'b0, acc[63:1]};
    divTrial = acc[63:31] - {1'b0, mcand};
    divNext  = divTrial[32] ? {acc[62:0], 1'b0} : {divTrial[31:0], acc[30:0], 1'b1};
    prodFix  = negQ ? (64'd0 - acc) : acc;
    quotFix  = negQ ? (32'd0 - acc[31:0]) : acc[31:0];
    remFix   = negR ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      cnt      <= '0;
      isDivReg <= 1'b0;
      divZero  <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      rawA     <= '0;
      mcand    <= '0;
      acc      <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (md.MDStart_IDEX) begin
`ifdef MULDIV_FAST_MULT_EN
            if (!isDiv) begin
              hiReg   <= fastProd[63:32];
              loReg   <= fastProd[31:0];
              doneReg <= 1'b1;
            end else begin
`else
            begin
`endif
              isDivReg <= isDiv;
              rawA     <= md.OpA_IDEX;
              negQ     <= sgnA ^ sgnB;
              negR     <= sgnA;
              cnt      <= '0;
              mcand    <= isDiv ? absB : absA;
              acc      <= {32'd0, isDiv ? absA : absB};
              divZero  <= isDiv && (md.OpB_IDEX == '0);
              state    <= (isDiv && (md.OpB_IDEX == '0)) ? FIX : CALC;
            end
          end else begin
            if (md.WrHi_IDEX) hiReg <= md.WrData_IDEX;
            if (md.WrLo_IDEX) loReg <= md.WrData_IDEX;
          end
        end
        CALC: begin
          if (md.Cancel) begin
            state <= IDLE;
          end else begin
            acc <= isDivReg ? divNext : mulNext;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!md.Cancel) begin
            doneReg <= 1'b1;
            if (divZero) begin
              hiReg <= rawA;
              loReg <= '1;
            end else if (isDivReg) begin
              hiReg <= remFix;
              loReg <= quotFix;
            end else begin
              hiReg <= prodFix[63:32];
              loReg <= prodFix[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.Busy     = (state != IDLE);
  assign md.Done     = doneReg;
  assign md.Hi       = hiReg;
  assign md.Lo       = loReg;
  assign md.MD_Stall = (state != IDLE) &&
                       (md.MDStart_IDEX || md.HiLoRd_IDEX || md.WrHi_IDEX || md.WrLo_IDEX);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched with hand-computed HI/LO results.
module tb_muldiv_sched;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_sched_if bus();

  muldiv_sched dut (
    .CLK   (clk),
    .RST_n (rstN),
    .md    (bus.slave)
  );

  task automatic clearInputs;
    bus.MDStart_IDEX = 1'b0;
    bus.MDOp_IDEX    = 2'b00;
    bus.OpA_IDEX     = '0;
    bus.OpB_IDEX     = '0;
    bus.HiLoRd_IDEX  = 1'b0;
    bus.WrHi_IDEX    = 1'b0;
    bus.WrLo_IDEX    = 1'b0;
    bus.WrData_IDEX  = '0;
    bus.Cancel       = 1'b0;
  endtask

  // Returns at the negedge following the start edge
  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.MDStart_IDEX = 1'b1;
    bus.MDOp_IDEX    = op;
    bus.OpA_IDEX     = a;
    bus.OpB_IDEX     = b;
    @(negedge clk);
    bus.MDStart_IDEX = 1'b0;
  endtask

  task automatic waitIdle(output int busyCnt);
    busyCnt = 0;
    while (bus.Busy === 1'b1 && busyCnt < 200) begin
      busyCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    clearInputs();
    rstN = 1'b0;
    #12;
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.Hi, 32'd0); end
    checks++; if (bus.Lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.Lo, 32'd0); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    bus.HiLoRd_IDEX = 1'b1;
    #1;
    checks++; if (bus.MD_Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.MD_Stall); end
    bus.HiLoRd_IDEX = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_divide;
    int n;
    startOp(2'b11, 32'd100, 32'd7);
    waitIdle(n);
    checks++; if (n !== 33) begin failures++; $display("FAIL divu_busy got=%0d exp=33", n); end
    checks++; if (bus.Lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=%h", bus.Lo, 32'd14); end
    checks++; if (bus.Hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=%h", bus.Hi, 32'd2); end
    checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL divu_done got=%b exp=1", bus.Done); end
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL divu_done_pulse got=%b exp=0", bus.Done); end

    startOp(2'b10, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n);
    checks++; if (bus.Lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=%h", bus.Lo, 32'hFFFF_FFFD); end
    checks++; if (bus.Hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=%h", bus.Hi, 32'hFFFF_FFFF); end

    startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n);
    checks++; if (bus.Lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=%h", bus.Lo, 32'h8000_0000); end
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=%h", bus.Hi, 32'd0); end
  endtask

  task automatic test_div_zero;
    int n;
    startOp(2'b10, 32'd5, 32'd0);
    waitIdle(n);
    checks++; if (n !== 1) begin failures++; $display("FAIL divz_busy got=%0d exp=1", n); end
    checks++; if (bus.Hi !== 32'd5) begin failures++; $display("FAIL divz_hi got=%h exp=%h", bus.Hi, 32'd5); end
    checks++; if (bus.Lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_lo got=%h exp=%h", bus.Lo, 32'hFFFF_FFFF); end
    checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL divz_done got=%b exp=1", bus.Done); end
  endtask

  task automatic test_mflo_stall;
    int s;
    startOp(2'b10, 32'd1000, 32'hFFFF_FFFD);
    bus.HiLoRd_IDEX = 1'b1;
    #1;
    s = 0;
    while (bus.MD_Stall === 1'b1 && s < 200) begin
      s++;
      @(negedge clk);
    end
    checks++; if (s !== 33) begin failures++; $display("FAIL mflo_stall_cycles got=%0d exp=33", s); end
    checks++; if (bus.Lo !== 32'hFFFF_FEB3) begin failures++; $display("FAIL mflo_lo got=%h exp=%h", bus.Lo, 32'hFFFF_FEB3); end
    checks++; if (bus.Hi !== 32'd1) begin failures++; $display("FAIL mflo_hi got=%h exp=%h", bus.Hi, 32'd1); end
    checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL mflo_done got=%b exp=1", bus.Done); end
    bus.HiLoRd_IDEX = 1'b0;
  endtask

`ifdef MULDIV_FAST_MULT_EN
  task automatic test_fast_mult;
    @(negedge clk);
    bus.MDStart_IDEX = 1'b1;
    bus.MDOp_IDEX    = 2'b01;
    bus.OpA_IDEX     = 32'hFFFF_FFFF;
    bus.OpB_IDEX     = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.MD_Stall !== 1'b0) begin failures++; $display("FAIL fast_stall got=%b exp=0", bus.MD_Stall); end
    @(posedge clk);
    #1;
    checks++; if (bus.Hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL fast_hi got=%h exp=%h", bus.Hi, 32'hFFFF_FFFE); end
    checks++; if (bus.Lo !== 32'd1) begin failures++; $display("FAIL fast_lo got=%h exp=%h", bus.Lo, 32'd1); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL fast_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL fast_done got=%b exp=1", bus.Done); end
    @(negedge clk);
    bus.MDStart_IDEX = 1'b0;
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL fast_done_pulse got=%b exp=0", bus.Done); end
  endtask
`else
  task automatic test_mult;
    int n;
    startOp(2'b00, 32'hFFFF_FFFE, 32'd3);
    waitIdle(n);
    checks++; if (n !== 33) begin failures++; $display("FAIL mult_busy got=%0d exp=33", n); end
    checks++; if (bus.Hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", bus.Hi, 32'hFFFF_FFFF); end
    checks++; if (bus.Lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=%h", bus.Lo, 32'hFFFF_FFFA); end
    checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL mult_done got=%b exp=1", bus.Done); end
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", bus.Done); end
  endtask

  task automatic test_back_to_back;
    int s;
    int n;
    startOp(2'b01, 32'h0001_0000, 32'h0001_0000);
    bus.MDStart_IDEX = 1'b1;
    bus.MDOp_IDEX    = 2'b00;
    bus.OpA_IDEX     = 32'hFFFF_FFFB;
    bus.OpB_IDEX     = 32'hFFFF_FFF9;
    #1;
    s = 0;
    while (bus.MD_Stall === 1'b1 && s < 200) begin
      s++;
      @(negedge clk);
    end
    checks++; if (s !== 33) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=33", s); end
    checks++; if (bus.Hi !== 32'd1) begin failures++; $display("FAIL b2b_first_hi got=%h exp=%h", bus.Hi, 32'd1); end
    checks++; if (bus.Lo !== 32'd0) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.Lo, 32'd0); end
    @(negedge clk);
    bus.MDStart_IDEX = 1'b0;
    waitIdle(n);
    checks++; if (n !== 33) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=33", n); end
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL b2b_second_hi got=%h exp=%h", bus.Hi, 32'd0); end
    checks++; if (bus.Lo !== 32'h23) begin failures++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.Lo, 32'h23); end
  endtask

  task automatic test_mthi_conflict;
    int n;
    @(negedge clk);
    bus.MDStart_IDEX = 1'b1;
    bus.MDOp_IDEX    = 2'b01;
    bus.OpA_IDEX     = 32'd2;
    bus.OpB_IDEX     = 32'd3;
    bus.WrHi_IDEX    = 1'b1;
    bus.WrLo_IDEX    = 1'b1;
    bus.WrData_IDEX  = 32'hDEAD_BEEF;
    @(negedge clk);
    clearInputs();
    waitIdle(n);
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL conflict_hi got=%h exp=%h", bus.Hi, 32'd0); end
    checks++; if (bus.Lo !== 32'd6) begin failures++; $display("FAIL conflict_lo got=%h exp=%h", bus.Lo, 32'd6); end
  endtask

  task automatic test_cancel;
    int doneSeen;
    @(negedge clk);
    bus.WrHi_IDEX   = 1'b1;
    bus.WrData_IDEX = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.WrHi_IDEX   = 1'b0;
    bus.WrLo_IDEX   = 1'b1;
    bus.WrData_IDEX = 32'h0BAD_F00D;
    @(negedge clk);
    bus.WrLo_IDEX   = 1'b0;
    checks++; if (bus.Hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mthi got=%h exp=%h", bus.Hi, 32'hA5A5_A5A5); end
    checks++; if (bus.Lo !== 32'h0BAD_F00D) begin failures++; $display("FAIL mtlo got=%h exp=%h", bus.Lo, 32'h0BAD_F00D); end
    startOp(2'b00, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    bus.Cancel = 1'b1;
    @(negedge clk);
    bus.Cancel = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", bus.Busy); end
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checks++; if (doneSeen !== 0) begin failures++; $display("FAIL cancel_done got=%0d exp=0", doneSeen); end
    checks++; if (bus.Hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL cancel_hi got=%h exp=%h", bus.Hi, 32'hA5A5_A5A5); end
    checks++; if (bus.Lo !== 32'h0BAD_F00D) begin failures++; $display("FAIL cancel_lo got=%h exp=%h", bus.Lo, 32'h0BAD_F00D); end
  endtask
`endif

  task automatic test_reset_midop;
    startOp(2'b11, 32'h0000_FFFF, 32'd3);
    repeat (19) @(negedge clk);
    checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.Busy); end
    rstN = 1'b0;
    #1;
    checks++; if (bus.Hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=%h", bus.Hi, 32'd0); end
    checks++; if (bus.Lo !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=%h", bus.Lo, 32'd0); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.Busy); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (bus.Lo !== 32'd0) begin failures++; $display("FAIL rstmid_no_result got=%h exp=%h", bus.Lo, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_mflo_stall();
`ifdef MULDIV_FAST_MULT_EN
    test_fast_mult();
`else
    test_mult();
    test_back_to_back();
    test_mthi_conflict();
    test_cancel();
`endif
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
